// File: rtl/alarm_pkg.sv
// -----------------------------------------------------------------------------
// alarm_pkg
// Shared definitions for the alarm controller slice: FSM state encoding,
// BCD field limits and the snooze counter width.
// Optional feature macro used by alarm_ctrl: HOURLY_CHIME_EN.
// -----------------------------------------------------------------------------
package alarm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SET_HOUR = 3'd1,
        ST_SET_MIN  = 3'd2,
        ST_RING     = 3'd3,
        ST_SNOOZE   = 3'd4
    } alarm_state_t;

    localparam int unsigned HOUR_MAX = 23;
    localparam int unsigned MIN_MAX  = 59;
    localparam int unsigned SNOOZE_W = 10;

    // Snooze reload value in seconds, sized to the snooze counter.
    function automatic logic [SNOOZE_W-1:0] snooze_load(input int unsigned minutes);
        return SNOOZE_W'(minutes * 60);
    endfunction

endpackage

// File: rtl/alarm_bcd_cnt.sv
// -----------------------------------------------------------------------------
// alarm_bcd_cnt
// Two-digit BCD field register with increment enable. Wraps from MAX to 00.
// Ports:
//   clk_i    in   clock
//   rst_ni   in   asynchronous reset, active-low (clears to 00)
//   inc_i    in   increment by one (BCD) on this clock edge
//   tens_o   out  tens digit  [TENS_W-1:0]
//   units_o  out  units digit [3:0]
// -----------------------------------------------------------------------------
module alarm_bcd_cnt #(
    parameter int unsigned TENS_W = 3,
    parameter int unsigned MAX    = 59
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              inc_i,
    output logic [TENS_W-1:0] tens_o,
    output logic [3:0]        units_o
);

    localparam logic [TENS_W-1:0] MAX_T = TENS_W'(MAX / 10);
    localparam logic [3:0]        MAX_U = 4'(MAX % 10);

    logic [TENS_W-1:0] tens_q,  tens_d;
    logic [3:0]        units_q, units_d;

    always_comb begin
        tens_d  = tens_q;
        units_d = units_q;
        if (inc_i) begin
            if (tens_q == MAX_T && units_q == MAX_U) begin
                tens_d  = '0;
                units_d = '0;
            end else if (units_q == 4'd9) begin
                units_d = '0;
                tens_d  = tens_q + TENS_W'(1);
            end else begin
                units_d = units_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tens_q  <= '0;
            units_q <= '0;
        end else begin
            tens_q  <= tens_d;
            units_q <= units_d;
        end
    end

    assign tens_o  = tens_q;
    assign units_o = units_q;

endmodule

// File: rtl/alarm_ctrl.sv
// -----------------------------------------------------------------------------
// alarm_ctrl
// Alarm controller for the 24-hour clock. Holds a BCD alarm time, sequences
// its setting via ALMKEY/SELECT/ADJUST, compares it against the live time and
// runs the ring/snooze cycle.
// Optional feature macro: HOURLY_CHIME_EN (one-second chime on the hour in
// IDLE while armed). Default build has no chime.
// Ports:
//   CLK, RST (async active-low), EN1HZ (1 s pulse), SIG2HZ (2 Hz square)
//   ALMKEY/SELECT/ADJUST  one-CLK key pulses
//   SECH/SECL/MINH/MINL/HOURH/HOURL  live BCD time
//   AMINH/AMINL/AHOURH/AHOURL  alarm time (BCD)
//   AMINON/AHOURON  blink enables, SETTING  alarm-set display select
//   ARMED  alarm armed, BUZZ  buzzer drive
// -----------------------------------------------------------------------------
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int unsigned RING_SEC   = 60,
    parameter int unsigned SNOOZE_MIN = 5
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       EN1HZ,
    input  logic       SIG2HZ,
    input  logic       ALMKEY,
    input  logic       SELECT,
    input  logic       ADJUST,
    input  logic [2:0] SECH,
    input  logic [3:0] SECL,
    input  logic [2:0] MINH,
    input  logic [3:0] MINL,
    input  logic [1:0] HOURH,
    input  logic [3:0] HOURL,
    output logic [2:0] AMINH,
    output logic [3:0] AMINL,
    output logic [1:0] AHOURH,
    output logic [3:0] AHOURL,
    output logic       AMINON,
    output logic       AHOURON,
    output logic       SETTING,
    output logic       ARMED,
    output logic       BUZZ
);

    localparam logic [7:0]          RING_LIM = 8'(RING_SEC);
    localparam logic [SNOOZE_W-1:0] SNZ_LOAD = snooze_load(SNOOZE_MIN);

    alarm_state_t        state_q;
    logic                armed_q;
    logic                match_q;
    logic [7:0]          ring_cnt_q, ring_cnt_d;
    logic [SNOOZE_W-1:0] snz_cnt_q,  snz_cnt_d;

    logic hour_inc, min_inc;
    logic match, trigger;

    // ALMKEY outranks ADJUST, so an edit is dropped when both arrive together.
    assign hour_inc = (state_q == ST_SET_HOUR) && !ALMKEY && ADJUST;
    assign min_inc  = (state_q == ST_SET_MIN)  && !ALMKEY && ADJUST;

    alarm_bcd_cnt #(.TENS_W(2), .MAX(HOUR_MAX)) u_hour (
        .clk_i   (CLK),
        .rst_ni  (RST),
        .inc_i   (hour_inc),
        .tens_o  (AHOURH),
        .units_o (AHOURL)
    );

    alarm_bcd_cnt #(.TENS_W(3), .MAX(MIN_MAX)) u_min (
        .clk_i   (CLK),
        .rst_ni  (RST),
        .inc_i   (min_inc),
        .tens_o  (AMINH),
        .units_o (AMINL)
    );

    assign match = ({HOURH, HOURL, MINH, MINL} == {AHOURH, AHOURL, AMINH, AMINL})
                   && (SECH == 3'd0) && (SECL == 4'd0);

    // match_q tracks every cycle, so a match that rises outside IDLE is
    // already "old" if the FSM returns to IDLE within the same second.
    assign trigger = match && !match_q && armed_q && (state_q == ST_IDLE);

    assign ring_cnt_d = ring_cnt_q + 8'd1;
    assign snz_cnt_d  = snz_cnt_q - SNOOZE_W'(1);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            armed_q    <= 1'b0;
            match_q    <= 1'b0;
            ring_cnt_q <= '0;
            snz_cnt_q  <= '0;
        end else begin
            match_q <= match;
            case (state_q)
                ST_IDLE: begin
                    if (ALMKEY) begin
                        state_q <= ST_SET_HOUR;
                    end else if (ADJUST) begin
                        armed_q <= ~armed_q;
                    end else if (trigger) begin
                        state_q    <= ST_RING;
                        ring_cnt_q <= '0;
                    end
                end
                ST_SET_HOUR: begin
                    if (ALMKEY) begin
                        state_q <= ST_IDLE;
                        armed_q <= 1'b1;
                    end else if (!ADJUST && SELECT) begin
                        state_q <= ST_SET_MIN;
                    end
                end
                ST_SET_MIN: begin
                    if (ALMKEY) begin
                        state_q <= ST_IDLE;
                        armed_q <= 1'b1;
                    end else if (!ADJUST && SELECT) begin
                        state_q <= ST_SET_HOUR;
                    end
                end
                ST_RING: begin
                    if (ALMKEY) begin
                        state_q <= ST_IDLE;
                    end else if (ADJUST) begin
                        state_q   <= ST_SNOOZE;
                        snz_cnt_q <= SNZ_LOAD;
                    end else if (EN1HZ) begin
                        ring_cnt_q <= ring_cnt_d;
                        if (ring_cnt_d == RING_LIM) begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_SNOOZE: begin
                    if (ALMKEY) begin
                        state_q <= ST_IDLE;
                    end else if (EN1HZ) begin
                        snz_cnt_q <= snz_cnt_d;
                        if (snz_cnt_d == '0) begin
                            state_q    <= ST_RING;
                            ring_cnt_q <= '0;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign SETTING = (state_q == ST_SET_HOUR) || (state_q == ST_SET_MIN);
    assign AHOURON = (state_q == ST_SET_HOUR) ? SIG2HZ : 1'b1;
    assign AMINON  = (state_q == ST_SET_MIN)  ? SIG2HZ : 1'b1;
    assign ARMED   = armed_q;

`ifdef HOURLY_CHIME_EN
    logic chime_q;
    logic chime_cond, chime_cond_q;

    assign chime_cond = (MINH == 3'd0) && (MINL == 4'd0) && (SECH == 3'd0) && (SECL == 4'd0);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            chime_q      <= 1'b0;
            chime_cond_q <= 1'b0;
        end else begin
            chime_cond_q <= chime_cond;
            // Start wins over the EN1HZ that normally accompanies the hour roll.
            if ((state_q == ST_IDLE) && chime_cond && !chime_cond_q && armed_q
                && !trigger && !ALMKEY && !ADJUST) begin
                chime_q <= 1'b1;
            end else if (EN1HZ || (state_q != ST_IDLE)) begin
                chime_q <= 1'b0;
            end
        end
    end

    assign BUZZ = (state_q == ST_RING) ? SIG2HZ : (chime_q && (state_q == ST_IDLE));
`else
    assign BUZZ = (state_q == ST_RING) && SIG2HZ;
`endif

endmodule

// File: tb/tb_alarm_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alarm_ctrl
// Self-checking bench for alarm_ctrl (default build). A behavioural model
// tracks alarm time as integers and ring/snooze as seconds remaining; every
// cycle the DUT outputs are compared against it. A vector table and
// hand-written sequences add explicit constant expectations.
// -----------------------------------------------------------------------------
module tb_alarm_ctrl;

    localparam int RING_SEC   = 60;
    localparam int SNOOZE_MIN = 5;

    logic       CLK = 1'b0;
    logic       RST, EN1HZ, SIG2HZ, ALMKEY, SELECT, ADJUST;
    logic [2:0] SECH;
    logic [3:0] SECL;
    logic [2:0] MINH;
    logic [3:0] MINL;
    logic [1:0] HOURH;
    logic [3:0] HOURL;
    logic [2:0] AMINH;
    logic [3:0] AMINL;
    logic [1:0] AHOURH;
    logic [3:0] AHOURL;
    logic       AMINON, AHOURON, SETTING, ARMED, BUZZ;

    alarm_ctrl #(.RING_SEC(RING_SEC), .SNOOZE_MIN(SNOOZE_MIN)) dut (
        .CLK(CLK), .RST(RST), .EN1HZ(EN1HZ), .SIG2HZ(SIG2HZ),
        .ALMKEY(ALMKEY), .SELECT(SELECT), .ADJUST(ADJUST),
        .SECH(SECH), .SECL(SECL), .MINH(MINH), .MINL(MINL),
        .HOURH(HOURH), .HOURL(HOURL),
        .AMINH(AMINH), .AMINL(AMINL), .AHOURH(AHOURH), .AHOURL(AHOURL),
        .AMINON(AMINON), .AHOURON(AHOURON), .SETTING(SETTING),
        .ARMED(ARMED), .BUZZ(BUZZ)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    // Behavioural model
    typedef enum {M_IDLE, M_SETH, M_SETM, M_RING, M_SNZ} mstate_e;
    mstate_e m_st;
    int      m_ah, m_am;
    bit      m_armed, m_prev_match;
    int      m_ring_left, m_snz_left;
    int      t_h, t_m, t_s;
    int      sig_div;

    typedef struct {
        bit a, s, j, e;
        int ah, am;
        bit armed, setting;
    } vec_t;
    vec_t vt[15];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_time(input int h, input int m, input int s);
        t_h = h; t_m = m; t_s = s;
        HOURH = 2'(h / 10); HOURL = 4'(h % 10);
        MINH  = 3'(m / 10); MINL  = 4'(m % 10);
        SECH  = 3'(s / 10); SECL  = 4'(s % 10);
    endtask

    task automatic model_reset();
        m_st = M_IDLE; m_ah = 0; m_am = 0; m_armed = 0; m_prev_match = 0;
        m_ring_left = 0; m_snz_left = 0;
    endtask

    task automatic model_step(input bit a, input bit s, input bit j, input bit e);
        bit match;
        bit rise;
        match = (t_h == m_ah) && (t_m == m_am) && (t_s == 0);
        rise  = match && !m_prev_match;
        m_prev_match = match;
        case (m_st)
            M_IDLE: begin
                if (a) m_st = M_SETH;
                else if (j) m_armed = !m_armed;
                else if (rise && m_armed) begin
                    m_st = M_RING; m_ring_left = RING_SEC;
                end
            end
            M_SETH: begin
                if (a) begin m_st = M_IDLE; m_armed = 1; end
                else if (j) m_ah = (m_ah + 1) % 24;
                else if (s) m_st = M_SETM;
            end
            M_SETM: begin
                if (a) begin m_st = M_IDLE; m_armed = 1; end
                else if (j) m_am = (m_am + 1) % 60;
                else if (s) m_st = M_SETH;
            end
            M_RING: begin
                if (a) m_st = M_IDLE;
                else if (j) begin m_st = M_SNZ; m_snz_left = SNOOZE_MIN * 60; end
                else if (e) begin
                    m_ring_left--;
                    if (m_ring_left == 0) m_st = M_IDLE;
                end
            end
            M_SNZ: begin
                if (a) m_st = M_IDLE;
                else if (e) begin
                    m_snz_left--;
                    if (m_snz_left == 0) begin m_st = M_RING; m_ring_left = RING_SEC; end
                end
            end
            default: m_st = M_IDLE;
        endcase
    endtask

    task automatic check_all();
        check("ahour_tens",  int'(AHOURH), m_ah / 10);
        check("ahour_units", int'(AHOURL), m_ah % 10);
        check("amin_tens",   int'(AMINH),  m_am / 10);
        check("amin_units",  int'(AMINL),  m_am % 10);
        check("armed",       int'(ARMED),  int'(m_armed));
        check("setting",     int'(SETTING), int'(m_st == M_SETH || m_st == M_SETM));
        check("buzz",        int'(BUZZ),   int'((m_st == M_RING) && SIG2HZ));
        check("ahouron",     int'(AHOURON), (m_st == M_SETH) ? int'(SIG2HZ) : 1);
        check("aminon",      int'(AMINON),  (m_st == M_SETM) ? int'(SIG2HZ) : 1);
    endtask

    // One clock cycle with the given key/second pulses.
    task automatic cyc(input bit a, input bit s, input bit j, input bit e);
        ALMKEY = a; SELECT = s; ADJUST = j; EN1HZ = e;
        model_step(a, s, j, e);
        @(posedge CLK);
        #1;
        ALMKEY = 0; SELECT = 0; ADJUST = 0; EN1HZ = 0;
        check_all();
        sig_div++;
        if (sig_div == 2) begin
            sig_div = 0;
            SIG2HZ  = ~SIG2HZ;
        end
    endtask

    task automatic do_reset();
        RST = 0;
        #2;
        model_reset();
        check_all();
        RST = 1;
        #1;
    endtask

    task automatic expect_ringing(input string name);
        bit seen = 0;
        repeat (4) begin
            cyc(0, 0, 0, 0);
            if (BUZZ) seen = 1;
        end
        check(name, int'(seen), 1);
    endtask

    task automatic expect_silent(input string name);
        bit seen = 0;
        repeat (4) begin
            cyc(0, 0, 0, 0);
            if (BUZZ) seen = 1;
        end
        check(name, int'(seen), 0);
    endtask

    // Assumes alarm is 00:00 and FSM is IDLE.
    task automatic set_alarm(input int h, input int m);
        cyc(1, 0, 0, 0);
        repeat (h) cyc(0, 0, 1, 0);
        cyc(0, 1, 0, 0);
        repeat (m) cyc(0, 0, 1, 0);
        cyc(1, 0, 0, 0);
    endtask

    // Fresh rising match of 07:30:00 while armed in IDLE.
    task automatic trigger_ring();
        set_time(7, 29, 59);
        cyc(0, 0, 0, 1);
        set_time(7, 30, 0);
        cyc(0, 0, 0, 1);
    endtask

    initial begin
        RST = 0; EN1HZ = 0; SIG2HZ = 0; ALMKEY = 0; SELECT = 0; ADJUST = 0;
        sig_div = 0;
        set_time(0, 0, 0);
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        RST = 1;
        #1;
        // Reset state
        check("rst_ahour", int'(AHOURH) * 10 + int'(AHOURL), 0);
        check("rst_amin",  int'(AMINH) * 10 + int'(AMINL), 0);
        check("rst_armed", int'(ARMED), 0);
        check("rst_buzz",  int'(BUZZ), 0);
        check("rst_setting", int'(SETTING), 0);
        check("rst_aminon",  int'(AMINON), 1);
        check("rst_ahouron", int'(AHOURON), 1);
        repeat (6) cyc(0, 0, 0, 1);
        expect_silent("rst_no_ring_at_0000");

        // Vector table: key handling and priorities, time held off-match.
        vt[0]  = '{0,0,0,0, 0,0, 0,0};
        vt[1]  = '{0,1,0,0, 0,0, 0,0};
        vt[2]  = '{0,0,1,0, 0,0, 1,0};
        vt[3]  = '{0,0,1,0, 0,0, 0,0};
        vt[4]  = '{1,0,0,0, 0,0, 0,1};
        vt[5]  = '{0,0,1,0, 1,0, 0,1};
        vt[6]  = '{0,0,1,0, 2,0, 0,1};
        vt[7]  = '{0,1,0,0, 2,0, 0,1};
        vt[8]  = '{0,0,1,0, 2,1, 0,1};
        vt[9]  = '{0,1,1,0, 2,2, 0,1};
        vt[10] = '{0,1,0,0, 2,2, 0,1};
        vt[11] = '{0,0,1,0, 3,2, 0,1};
        vt[12] = '{1,0,1,0, 3,2, 1,0};
        vt[13] = '{0,0,1,0, 3,2, 0,0};
        vt[14] = '{0,1,1,0, 3,2, 1,0};
        set_time(12, 34, 56);
        for (int i = 0; i < 15; i++) begin
            cyc(vt[i].a, vt[i].s, vt[i].j, vt[i].e);
            check($sformatf("vec%0d_ahour", i), int'(AHOURH) * 10 + int'(AHOURL), vt[i].ah);
            check($sformatf("vec%0d_amin", i),  int'(AMINH) * 10 + int'(AMINL), vt[i].am);
            check($sformatf("vec%0d_armed", i), int'(ARMED), int'(vt[i].armed));
            check($sformatf("vec%0d_setting", i), int'(SETTING), int'(vt[i].setting));
        end

        // Hour wrap 23 -> 00, minute wrap 59 -> 00 without hour carry.
        do_reset();
        cyc(1, 0, 0, 0);
        repeat (23) cyc(0, 0, 1, 0);
        check("hour_23", int'(AHOURH) * 10 + int'(AHOURL), 23);
        cyc(0, 0, 1, 0);
        check("hour_wrap", int'(AHOURH) * 10 + int'(AHOURL), 0);
        cyc(0, 1, 0, 0);
        repeat (61) cyc(0, 0, 1, 0);
        check("min_wrap", int'(AMINH) * 10 + int'(AMINL), 1);
        check("min_no_carry", int'(AHOURH) * 10 + int'(AHOURL), 0);
        cyc(1, 0, 0, 0);
        check("set_exit_armed", int'(ARMED), 1);
        check("set_exit_setting", int'(SETTING), 0);

        // 07:30 ring and auto-stop after RING_SEC seconds.
        do_reset();
        set_alarm(7, 30);
        check("armed_0730", int'(ARMED), 1);
        trigger_ring();
        expect_ringing("ring_start");
        repeat (RING_SEC - 1) cyc(0, 0, 0, 1);
        expect_ringing("ring_before_timeout");
        cyc(0, 0, 0, 1);
        expect_silent("ring_timeout");
        check("armed_after_timeout", int'(ARMED), 1);

        // Snooze and re-ring.
        trigger_ring();
        cyc(0, 0, 1, 0);
        expect_silent("snooze_quiet");
        repeat (SNOOZE_MIN * 60 - 1) cyc(0, 0, 0, 1);
        expect_silent("snooze_before_expire");
        cyc(0, 0, 0, 1);
        expect_ringing("snooze_expire");
        cyc(1, 0, 0, 0);
        expect_silent("ring_stop");

        // ALMKEY beats ADJUST in RING: IDLE, never re-rings from snooze.
        trigger_ring();
        cyc(1, 0, 1, 0);
        expect_silent("almkey_adjust_idle");
        repeat (SNOOZE_MIN * 60 + 2) cyc(0, 0, 0, 1);
        expect_silent("not_snoozing");

        // Held match gives one trigger only.
        trigger_ring();
        cyc(1, 0, 0, 0);
        repeat (40) cyc(0, 0, 0, 1);
        expect_silent("held_match_once");

        // Match rising while in SET_HOUR never triggers.
        set_time(7, 29, 59);
        cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 0);
        set_time(7, 30, 0);
        cyc(0, 0, 0, 1);
        cyc(1, 0, 0, 0);
        check("set_exit_rearmed", int'(ARMED), 1);
        expect_silent("match_in_set_no_trigger");

        // Disarm, then no trigger at next match.
        set_time(7, 31, 0);
        cyc(0, 0, 1, 0);
        check("disarmed", int'(ARMED), 0);
        set_time(7, 30, 0);
        cyc(0, 0, 0, 1);
        expect_silent("disarmed_no_trigger");

        // Reset in the middle of a snooze.
        cyc(0, 0, 1, 0);
        trigger_ring();
        cyc(0, 0, 1, 0);
        repeat (10) cyc(0, 0, 0, 1);
        do_reset();
        check("snzrst_ahour", int'(AHOURH) * 10 + int'(AHOURL), 0);
        check("snzrst_amin",  int'(AMINH) * 10 + int'(AMINL), 0);
        check("snzrst_armed", int'(ARMED), 0);
        set_time(23, 59, 59);
        cyc(0, 0, 0, 1);
        set_time(0, 0, 0);
        repeat (SNOOZE_MIN * 60) cyc(0, 0, 0, 1);
        expect_silent("snzrst_no_ring");

        // Randomised traffic against the model.
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(7) == 0) begin
                case ($urandom_range(3))
                    0: set_time(m_ah, m_am, 0);
                    1: set_time(m_ah, m_am, int'($urandom_range(59)));
                    2: set_time(int'($urandom_range(23)), int'($urandom_range(59)),
                                int'($urandom_range(59)));
                    default: set_time(m_ah, (m_am + 59) % 60, 59);
                endcase
            end
            cyc($urandom_range(24) == 0, $urandom_range(9) == 0,
                $urandom_range(9) == 0, $urandom_range(3) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
